// File: rtl/mt_regfile_wb_pkg.sv
// Shared constants for the multithreaded writeback register file.
// Default widths, entry count and clear/run FSM encoding.
package mt_regfile_wb_pkg;

    localparam int DATAPATH_WIDTH     = 64;
    localparam int REGFILE_ADDR_WIDTH = 5;
    localparam int THREAD_BITS        = 2;
    localparam int RF_ENTRIES         = 1 << (THREAD_BITS + REGFILE_ADDR_WIDTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/mt_regfile_bank.sv
// Banked register storage: one write port, two registered read ports.
// A per-port override lets the parent substitute a value (zero / bypass) for the array read.
module mt_regfile_bank #(
    parameter int DATA_W  = 64,
    parameter int INDEX_W = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [INDEX_W-1:0]         waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       rd_en,
    input  logic [1:0][INDEX_W-1:0]    raddr,
    input  logic [1:0]                 ovr,
    input  logic [1:0][DATA_W-1:0]     ovr_data,
    output logic [1:0][DATA_W-1:0]     rd_data
);

    localparam int ENTRIES = 1 << INDEX_W;

    // No reset on the array so it maps onto block RAM; the parent sweeps it clear.
    logic [DATA_W-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] rd_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_reg <= '0;
                end else if (rd_en) begin
                    rd_reg <= ovr[gi] ? ovr_data[gi] : mem[raddr[gi]];
                end
            end

            assign rd_data[gi] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/mt_regfile_wb.sv
// Writeback stage: selects mem/accum result, commits to per-thread register file, clears on reset.
// Optional macro WB_BYPASS_EN: same-cycle read of the entry being written returns the new value.
module mt_regfile_wb #(
    parameter int DATAPATH_WIDTH     = mt_regfile_wb_pkg::DATAPATH_WIDTH,
    parameter int REGFILE_ADDR_WIDTH = mt_regfile_wb_pkg::REGFILE_ADDR_WIDTH,
    parameter int THREAD_BITS        = mt_regfile_wb_pkg::THREAD_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATAPATH_WIDTH-1:0]     wb_mem_data_in,
    input  logic [DATAPATH_WIDTH-1:0]     wb_accum_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] wb_addr_in,
    input  logic [THREAD_BITS-1:0]        wb_thread_id_in,
    input  logic                          wb_en_in,
    input  logic                          wb_mem_reg_sel_in,
    input  logic [THREAD_BITS-1:0]        rd_thread_id,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_b,
    input  logic                          rd_en,
    output logic [DATAPATH_WIDTH-1:0]     rd_data_a,
    output logic [DATAPATH_WIDTH-1:0]     rd_data_b,
    output logic [DATAPATH_WIDTH-1:0]     wb_data_out,
    output logic                          rf_ready
);

    import mt_regfile_wb_pkg::*;

    localparam int IDX_W = THREAD_BITS + REGFILE_ADDR_WIDTH;

    logic [0:0]       state_reg;
    logic [IDX_W-1:0] cnt_reg;
    logic             rf_ready_reg;
    logic             run;

    logic [IDX_W-1:0] wr_idx;
    logic             wr_fire;

    logic                                    bank_we;
    logic [IDX_W-1:0]                        bank_waddr;
    logic [DATAPATH_WIDTH-1:0]               bank_wdata;
    logic [1:0][IDX_W-1:0]                   rd_idx;
    logic [1:0][REGFILE_ADDR_WIDTH-1:0]      rd_reg_addr;
    logic [1:0]                              rd_ovr;
    logic [1:0][DATAPATH_WIDTH-1:0]          rd_ovr_data;
    logic [1:0][DATAPATH_WIDTH-1:0]          rd_q;

    assign wb_data_out = wb_mem_reg_sel_in ? wb_mem_data_in : wb_accum_in;
    assign run         = (state_reg == ST_RUN);
    assign rf_ready    = rf_ready_reg;

    // Sweep one entry per cycle; leaving CLEAR is final until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_CLEAR;
            cnt_reg      <= '0;
            rf_ready_reg <= 1'b0;
        end else if (state_reg == ST_CLEAR) begin
            cnt_reg <= cnt_reg + IDX_W'(1);
            if (&cnt_reg) begin
                state_reg    <= ST_RUN;
                rf_ready_reg <= 1'b1;
            end
        end
    end

    assign wr_idx  = {wb_thread_id_in, wb_addr_in};
    assign wr_fire = run && wb_en_in && (wb_addr_in != '0);

    // During CLEAR the write port belongs to the sweep; pipeline writes are dropped.
    assign bank_we    = !run || wr_fire;
    assign bank_waddr = run ? wr_idx : cnt_reg;
    assign bank_wdata = run ? wb_data_out : '0;

    assign rd_reg_addr[0] = rd_addr_a;
    assign rd_reg_addr[1] = rd_addr_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic zero_hit;
            logic byp_hit;

            assign rd_idx[gi] = {rd_thread_id, rd_reg_addr[gi]};
            assign zero_hit   = !run || (rd_reg_addr[gi] == '0);
`ifdef WB_BYPASS_EN
            assign byp_hit    = wr_fire && (rd_idx[gi] == wr_idx);
`else
            assign byp_hit    = 1'b0;
`endif
            assign rd_ovr[gi]      = zero_hit || byp_hit;
            assign rd_ovr_data[gi] = zero_hit ? '0 : wb_data_out;
        end
    endgenerate

    mt_regfile_bank #(
        .DATA_W  (DATAPATH_WIDTH),
        .INDEX_W (IDX_W)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .we       (bank_we),
        .waddr    (bank_waddr),
        .wdata    (bank_wdata),
        .rd_en    (rd_en),
        .raddr    (rd_idx),
        .ovr      (rd_ovr),
        .ovr_data (rd_ovr_data),
        .rd_data  (rd_q)
    );

    assign rd_data_a = rd_q[0];
    assign rd_data_b = rd_q[1];

endmodule

// File: tb/tb_mt_regfile_wb.sv
// Self-checking bench for mt_regfile_wb against an array-based reference model.
// Honours WB_BYPASS_EN when computing same-cycle read expectations.
module tb_mt_regfile_wb;

    import mt_regfile_wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] wb_mem_data_in;
    logic [63:0] wb_accum_in;
    logic [4:0]  wb_addr_in;
    logic [1:0]  wb_thread_id_in;
    logic        wb_en_in;
    logic        wb_mem_reg_sel_in;
    logic [1:0]  rd_thread_id;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        rd_en;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic [63:0] wb_data_out;
    logic        rf_ready;

    int errors = 0;
    int checks = 0;

    logic [63:0] model [RF_ENTRIES];
    bit          model_run = 1'b0;
    int          sweep_cnt = 0;
    logic [63:0] exp_a = '0;
    logic [63:0] exp_b = '0;

    mt_regfile_wb dut (
        .clk               (clk),
        .reset             (reset),
        .wb_mem_data_in    (wb_mem_data_in),
        .wb_accum_in       (wb_accum_in),
        .wb_addr_in        (wb_addr_in),
        .wb_thread_id_in   (wb_thread_id_in),
        .wb_en_in          (wb_en_in),
        .wb_mem_reg_sel_in (wb_mem_reg_sel_in),
        .rd_thread_id      (rd_thread_id),
        .rd_addr_a         (rd_addr_a),
        .rd_addr_b         (rd_addr_b),
        .rd_en             (rd_en),
        .rd_data_a         (rd_data_a),
        .rd_data_b         (rd_data_b),
        .wb_data_out       (wb_data_out),
        .rf_ready          (rf_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] sel_value();
        return wb_mem_reg_sel_in ? wb_mem_data_in : wb_accum_in;
    endfunction

    function automatic logic [63:0] read_expect(input logic [4:0] addr);
        int idx;
        idx = {rd_thread_id, addr};
        if (addr == 0) return 64'd0;
`ifdef WB_BYPASS_EN
        if (wb_en_in && wb_addr_in != 0 && idx == int'({wb_thread_id_in, wb_addr_in}))
            return sel_value();
`endif
        return model[idx];
    endfunction

    // Advance the reference model with the current inputs, then step one clock.
    task automatic clock_cycle();
        if (reset) begin
            model_run = 1'b0;
            sweep_cnt = 0;
            exp_a     = '0;
            exp_b     = '0;
        end else if (!model_run) begin
            if (rd_en) begin
                exp_a = '0;
                exp_b = '0;
            end
            sweep_cnt++;
            if (sweep_cnt == RF_ENTRIES) begin
                model_run = 1'b1;
                foreach (model[i]) model[i] = '0;
            end
        end else begin
            if (rd_en) begin
                exp_a = read_expect(rd_addr_a);
                exp_b = read_expect(rd_addr_b);
            end
            if (wb_en_in && wb_addr_in != 0)
                model[{wb_thread_id_in, wb_addr_in}] = sel_value();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_mem_data_in    = '0;
        wb_accum_in       = '0;
        wb_addr_in        = '0;
        wb_thread_id_in   = '0;
        wb_en_in          = 1'b0;
        wb_mem_reg_sel_in = 1'b0;
        rd_thread_id      = '0;
        rd_addr_a         = '0;
        rd_addr_b         = '0;
        rd_en             = 1'b0;
    endtask

    // Reset, then sweep: ready must rise on exactly the 128th edge; reads and writes during sweep are inert.
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) clock_cycle();
        checks++;
        if (rf_ready !== 1'b0 || rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: rf_ready=%0b a=%h b=%h, required 0/0/0", rf_ready, rd_data_a, rd_data_b);
        end
        reset           = 1'b0;
        rd_en           = 1'b1;
        rd_thread_id    = 2'd2;
        rd_addr_a       = 5'd7;
        rd_addr_b       = 5'd7;
        wb_en_in        = 1'b1;
        wb_thread_id_in = 2'd2;
        wb_addr_in      = 5'd7;
        wb_accum_in     = 64'hABCD;
        for (int k = 1; k <= 130; k++) begin
            if (k == 120) wb_en_in = 1'b0;
            clock_cycle();
            checks++;
            if (rf_ready !== (k >= 128)) begin
                errors++;
                $display("FAIL sweep_ready: edge %0d rf_ready=%0b, required %0b", k, rf_ready, k >= 128);
            end
            checks++;
            if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
                errors++;
                $display("FAIL sweep_read: edge %0d a=%h b=%h, required 0", k, rd_data_a, rd_data_b);
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        wb_en_in          = 1'b1;
        wb_thread_id_in   = 2'd1;
        wb_addr_in        = 5'd5;
        wb_mem_reg_sel_in = 1'b1;
        wb_mem_data_in    = 64'hDEAD_BEEF;
        wb_accum_in       = 64'h1234;
        clock_cycle();
        idle_inputs();
        rd_en        = 1'b1;
        rd_thread_id = 2'd1;
        rd_addr_a    = 5'd5;
        rd_addr_b    = 5'd5;
        clock_cycle();
        checks++;
        if (rd_data_a !== 64'hDEAD_BEEF || rd_data_b !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_read: a=%h b=%h, required deadbeef", rd_data_a, rd_data_b);
        end
        rd_thread_id = 2'd0;
        clock_cycle();
        checks++;
        if (rd_data_a !== 64'd0) begin
            errors++;
            $display("FAIL other_thread: a=%h, required 0", rd_data_a);
        end
        idle_inputs();
    endtask

    task automatic test_reg0();
        wb_en_in          = 1'b1;
        wb_thread_id_in   = 2'd2;
        wb_addr_in        = 5'd0;
        wb_mem_reg_sel_in = 1'b0;
        wb_accum_in       = 64'hFFFF;
        wb_mem_data_in    = 64'h5555;
        rd_en             = 1'b1;
        rd_thread_id      = 2'd2;
        rd_addr_a         = 5'd0;
        rd_addr_b         = 5'd0;
        #1;
        checks++;
        if (wb_data_out !== 64'hFFFF) begin
            errors++;
            $display("FAIL wb_data_mux: got %h, required ffff", wb_data_out);
        end
        clock_cycle();
        wb_en_in = 1'b0;
        clock_cycle();
        checks++;
        if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
            errors++;
            $display("FAIL reg0_read: a=%h b=%h, required 0", rd_data_a, rd_data_b);
        end
        idle_inputs();
    endtask

    task automatic test_same_cycle();
        logic [63:0] want;
        wb_en_in        = 1'b1;
        wb_thread_id_in = 2'd3;
        wb_addr_in      = 5'd9;
        wb_accum_in     = 64'h11;
        clock_cycle();
        wb_accum_in  = 64'h22;
        rd_en        = 1'b1;
        rd_thread_id = 2'd3;
        rd_addr_a    = 5'd9;
        rd_addr_b    = 5'd9;
        clock_cycle();
`ifdef WB_BYPASS_EN
        want = 64'h22;
`else
        want = 64'h11;
`endif
        checks++;
        if (rd_data_a !== want || rd_data_b !== want) begin
            errors++;
            $display("FAIL same_cycle: a=%h b=%h, required %h", rd_data_a, rd_data_b, want);
        end
        wb_en_in = 1'b0;
        clock_cycle();
        checks++;
        if (rd_data_a !== 64'h22) begin
            errors++;
            $display("FAIL after_write: a=%h, required 22", rd_data_a);
        end
        idle_inputs();
    endtask

    task automatic test_hold();
        rd_en        = 1'b1;
        rd_thread_id = 2'd1;
        rd_addr_a    = 5'd5;
        rd_addr_b    = 5'd0;
        clock_cycle();
        rd_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rd_thread_id = 2'(k + 2);
            rd_addr_a    = 5'd9;
            rd_addr_b    = 5'(k + 3);
            clock_cycle();
            checks++;
            if (rd_data_a !== 64'hDEAD_BEEF || rd_data_b !== 64'd0) begin
                errors++;
                $display("FAIL hold: a=%h b=%h, required deadbeef/0", rd_data_a, rd_data_b);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            wb_en_in          = ($urandom_range(3) != 0);
            wb_thread_id_in   = 2'($urandom);
            wb_addr_in        = 5'($urandom_range(7));
            wb_mem_reg_sel_in = 1'($urandom);
            wb_mem_data_in    = {$urandom, $urandom};
            wb_accum_in       = {$urandom, $urandom};
            rd_en             = ($urandom_range(4) != 0);
            rd_thread_id      = ($urandom_range(1) == 0) ? wb_thread_id_in : 2'($urandom);
            rd_addr_a         = ($urandom_range(2) == 0) ? wb_addr_in : 5'($urandom_range(7));
            rd_addr_b         = 5'($urandom_range(7));
            #1;
            checks++;
            if (wb_data_out !== sel_value()) begin
                errors++;
                $display("FAIL rand_mux: got %h, required %h", wb_data_out, sel_value());
            end
            clock_cycle();
            checks++;
            if (rd_data_a !== exp_a || rd_data_b !== exp_b || rf_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_read: it %0d a=%h b=%h rdy=%0b, required %h/%h/1",
                         k, rd_data_a, rd_data_b, rf_ready, exp_a, exp_b);
            end
        end
        idle_inputs();
    endtask

    // Abort the sweep at counter 60 with writes being attempted; the restart must take a full 128 cycles.
    task automatic test_mid_sweep_reset();
        reset = 1'b1;
        clock_cycle();
        reset           = 1'b0;
        wb_en_in        = 1'b1;
        wb_accum_in     = 64'h7777;
        for (int k = 0; k < 60; k++) begin
            wb_thread_id_in = 2'($urandom);
            wb_addr_in      = 5'($urandom_range(1, 31));
            clock_cycle();
        end
        checks++;
        if (rf_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_sweep_ready: rf_ready=%0b, required 0", rf_ready);
        end
        reset = 1'b1;
        clock_cycle();
        reset = 1'b0;
        for (int k = 1; k <= 128; k++) begin
            clock_cycle();
            checks++;
            if (rf_ready !== (k == 128)) begin
                errors++;
                $display("FAIL restart_ready: edge %0d rf_ready=%0b, required %0b", k, rf_ready, k == 128);
            end
        end
        idle_inputs();
        rd_en = 1'b1;
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < 32; r += 2) begin
                rd_thread_id = 2'(t);
                rd_addr_a    = 5'(r);
                rd_addr_b    = 5'(r + 1);
                clock_cycle();
                checks++;
                if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
                    errors++;
                    $display("FAIL cleared: t%0d r%0d a=%h b=%h, required 0", t, r, rd_data_a, rd_data_b);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_reg0();
        test_same_cycle();
        test_hold();
        test_random();
        test_mid_sweep_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
